// File: rtl/auto_correlator.sv
// Frame autocorrelation engine: load N samples, then one MAC per clock per lag,
// streaming r[k] with its signed lag under valid/ready flow control.
// state | meaning
// LOAD  | accepting samples into both RAM copies
// CALC  | read/MAC pipeline running for lag k
// EMIT  | r[k] presented, waiting for out_ready
module auto_correlator #(
  parameter int DATA_W  = 32,
  parameter int N       = 480,
  parameter int MAX_LAG = 479,
  parameter int ACC_W   = 2*DATA_W + $clog2(N),
  parameter int LAG_W   = $clog2(MAX_LAG+1) + 1
) (
  input  logic              Clk,
  input  logic              Reset_h,
  input  logic              full_mode,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sample_valid,
  output logic              sample_ready,
  output logic [ACC_W-1:0]  out_data,
  output logic [LAG_W-1:0]  out_lag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy
);

  localparam int IDX_W = $clog2(N);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N-1);
  localparam logic signed [LAG_W-1:0] LAG_HI = LAG_W'(MAX_LAG);
  localparam logic signed [LAG_W-1:0] LAG_LO = -LAG_HI;

  typedef enum logic [1:0] {S_LOAD, S_CALC, S_EMIT} state_t;
  state_t state, state_nxt;

  logic [DATA_W-1:0] mem_a [N];
  logic [DATA_W-1:0] mem_b [N];

  logic [IDX_W-1:0] wr_idx, rd_n, m_r, m_start;
  logic mode_r;
  logic signed [LAG_W-1:0] k_r, k_start, k_abs;
  logic issue_done, rd_v, rd_last, mac_last;
  logic signed [DATA_W-1:0] rd_a, rd_b;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0] acc, prod_ext;
  logic accept, frame_done, issue, emit_fire, enter_calc;

  assign accept     = sample_valid && sample_ready;
  assign frame_done = accept && (wr_idx == IDX_LAST);
  assign issue      = (state == S_CALC) && !issue_done;
  assign emit_fire  = (state == S_EMIT) && out_ready;
  assign enter_calc = frame_done || (emit_fire && (k_r != LAG_HI));

  assign prod     = rd_a * rd_b;
  assign prod_ext = ACC_W'(prod);

  // Lag and |lag| for the CALC pass about to start.
  always_comb begin
    k_start = k_r + LAG_W'(1);
    if (state == S_LOAD) k_start = mode_r ? LAG_LO : '0;
    k_abs   = k_start[LAG_W-1] ? -k_start : k_start;
    m_start = IDX_W'(k_abs);
  end

  always_ff @(posedge Clk or posedge Reset_h) begin
    if (Reset_h) state <= S_LOAD;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    sample_ready = 1'b0;
    out_valid    = 1'b0;
    out_last     = 1'b0;
    busy         = 1'b0;
    out_lag      = k_r;
    unique case (state)
      S_LOAD: begin
        sample_ready = 1'b1;
        if (frame_done) state_nxt = S_CALC;
      end
      S_CALC: begin
        busy = 1'b1;
        if (mac_last) state_nxt = S_EMIT;
      end
      S_EMIT: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_last  = (k_r == LAG_HI);
        if (out_ready) state_nxt = (k_r == LAG_HI) ? S_LOAD : S_CALC;
      end
      default: state_nxt = S_LOAD;
    endcase
  end

  // Two RAM copies written together give a second read port for x[n-m].
  always_ff @(posedge Clk) begin
    if (accept) begin
      mem_a[wr_idx] <= sample_in;
      mem_b[wr_idx] <= sample_in;
    end
    rd_a <= mem_a[rd_n];
    rd_b <= mem_b[rd_n - m_r];
  end

  always_ff @(posedge Clk or posedge Reset_h) begin
    if (Reset_h) begin
      wr_idx     <= '0;
      mode_r     <= 1'b0;
      k_r        <= '0;
      m_r        <= '0;
      rd_n       <= '0;
      issue_done <= 1'b1;
      rd_v       <= 1'b0;
      rd_last    <= 1'b0;
      mac_last   <= 1'b0;
      acc        <= '0;
      out_data   <= '0;
    end else begin
      if (accept) begin
        wr_idx <= frame_done ? '0 : wr_idx + IDX_W'(1);
        if (wr_idx == '0) mode_r <= full_mode;
      end
      if (emit_fire && (k_r == LAG_HI)) wr_idx <= '0;

      rd_v     <= issue;
      rd_last  <= issue && (rd_n == IDX_LAST);
      mac_last <= rd_last;
      if (issue) begin
        if (rd_n == IDX_LAST) issue_done <= 1'b1;
        else                  rd_n <= rd_n + IDX_W'(1);
      end
      if (rd_v) acc <= acc + prod_ext;
      if (mac_last) out_data <= acc;

      if (enter_calc) begin
        k_r        <= k_start;
        m_r        <= m_start;
        rd_n       <= m_start;
        issue_done <= 1'b0;
        acc        <= '0;
      end
    end
  end

endmodule
